seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised serial-bit sequence detector, the generalised successor to the fixed 3-state "101" Mealy detector. It detects a runtime-programmable pattern of 1..PATTERN_W bits on a qualified serial input and raises a same-cycle (Mealy) match flag. It selects overlapping or non-overlapping detection at runtime and keeps a saturating match counter. It sits on the serial receive path ahead of framing/sync logic.

## Interface
- PATTERN_W, 8: maximum pattern length in bits (≥2).
- CNT_W, 16: match counter width.
- LEN_W, $clog2(PATTERN_W+1): width of pat_len (derived, not overridden).
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- x  in  1  serial data bit.
- in_valid  in  1  x is a valid bit this cycle; only valid cycles advance the detector.
- cfg_load  in  1  one-cycle strobe that latches pattern/pat_len/overlap and restarts detection.
- pattern  in  PATTERN_W  pattern bits; pattern[pat_len-1] is the first bit received, pattern[0] the last.
- pat_len  in  LEN_W  pattern length; legal 1..PATTERN_W.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- cnt_clr  in  1  synchronous clear of match_count.
- z  out  1  Mealy match flag, combinational.
- match_count  out  CNT_W  saturating count of matches.

## Operation
- Registered state:
  - hist[PATTERN_W-1:0]: shift history of valid bits, newest in bit 0.
  - fill: bits accumulated since the last restart, saturating at PATTERN_W.
  - cfg_pat, cfg_len, cfg_ovl: configuration copies latched by cfg_load.
- Window: w = {hist[PATTERN_W-2:0], x}. match = in_valid & cfg_len legal & (fill+1 ≥ cfg_len) & (w[cfg_len-1:0] == cfg_pat[cfg_len-1:0]).
- z = match & ~cfg_load. z is never gated by registered output logic.
- Valid cycle without cfg_load:
  - hist ← w.
  - If match and cfg_ovl=0: fill ← 0, so the pattern's bits are not reused.
  - Otherwise: fill ← min(fill+1, PATTERN_W).
- Invalid cycle: all state holds, z=0.
- cfg_load:
  - Latches the configuration and clears hist and fill.
  - The same-cycle x is discarded and z=0; cfg_load wins over in_valid.
  - Does not clear match_count.
- Illegal cfg_len (0 or >PATTERN_W): z is permanently 0 and fill still advances.
- match_count:
  - +1 on each cycle with z=1, saturating at 2^CNT_W−1.
  - cnt_clr has priority: a clear coincident with a match yields 0.
- Reset values:
  - hist=0, fill=0, match_count=0.
  - cfg_pat=0, cfg_len=0 (illegal, detector idle until the first cfg_load), cfg_ovl=1.
  - z=0.

## Timing
- z asserts in the same cycle as the final pattern bit (combinational from state, x, in_valid). Zero latency.
- match_count reflects a match on the following rising edge (1-cycle latency).
- New configuration is effective starting with the first valid bit after the cfg_load edge.
- The earliest match after a restart is the cfg_len-th valid bit.
- Asynchronous rst mid-stream drops all partial progress immediately. The detector is idle again until cfg_load.
- in_valid gaps of any length are transparent: detection depends only on the order of valid bits.

## Structure
- Package seq_det_pkg holds:
  - OVL_ON=1'b1 and OVL_OFF=1'b0 constants.
  - CNT_MAX helper.
  - len_legal(len, max) function.
- Sub-module seq_det_window_cmp: combinational masked compare of w against cfg_pat under cfg_len, producing raw match. The top level holds all registers.

## Test plan
- Overlap, pattern=3'b101, len 3; valid bits 1,0,1,0,1,0,1 → z high on bits 3, 5, 7; match_count=3.
- Non-overlap, same pattern and stream → z on bits 3 and 7 only; match_count=2.
- PATTERN_W=8, pattern=8'hA5, len 8; stream 1010_0101 with in_valid low for 2 cycles between every bit → single z on the 8th valid bit and never on invalid cycles.
- CNT_W=4, overlap, len 1, pattern=1; 20 valid 1s → match_count saturates at 15; a cnt_clr pulse coinciding with a match → 0.
- cfg_load after bits 1,0 of "101" with the same config, then bit 1 → no z, because progress is cleared. rst asserted mid-stream → all outputs 0 asynchronously, and z stays 0 until the next cfg_load.
- pat_len=0 and pat_len=9 (PATTERN_W=8), random stream → z never asserts and match_count stays 0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared constants and helpers for the parametrised serial sequence detector.
//   OVL_ON / OVL_OFF : encodings of the overlap-mode configuration bit
//   cnt_max(w)       : all-ones value of a w-bit counter (saturation limit)
//   len_legal(l, m)  : 1 when pattern length l is usable (1..m)
// -----------------------------------------------------------------------------
package seq_det_pkg;

    localparam logic OVL_ON  = 1'b1;
    localparam logic OVL_OFF = 1'b0;

    // Saturation limit of a w-bit counter; w = 64 wraps the shift to zero and
    // the subtraction then yields all ones, which is still the right answer.
    function automatic logic [63:0] cnt_max(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic len_legal(input logic [31:0] len, input logic [31:0] max);
        return (len != 32'd0) && (len <= max);
    endfunction

endpackage

// File: rtl/seq_det_window_cmp.sv
// -----------------------------------------------------------------------------
// seq_det_window_cmp
// Combinational masked compare of the bit window against the configured
// pattern. Only the low cfg_len bits take part; the upper bits are don't-care.
// Length legality and fill qualification are handled by the caller.
//   w         in  PATTERN_W  window, newest bit in w[0]
//   cfg_pat   in  PATTERN_W  latched pattern, last-received bit in cfg_pat[0]
//   cfg_len   in  LEN_W      latched pattern length
//   raw_match out 1          low cfg_len bits of w equal those of cfg_pat
// -----------------------------------------------------------------------------
module seq_det_window_cmp
    import seq_det_pkg::*;
#(
    parameter  int PATTERN_W = 8,
    localparam int LEN_W     = $clog2(PATTERN_W + 1)
) (
    input  logic [PATTERN_W-1:0] w,
    input  logic [PATTERN_W-1:0] cfg_pat,
    input  logic [LEN_W-1:0]     cfg_len,
    output logic                 raw_match
);

    logic [PATTERN_W-1:0] mask;

    always_comb begin
        // NOTE: every always_comb output gets a default before any conditional
        // logic, so no path can leave it unassigned and infer a latch.
        mask      = '0;
        raw_match = 1'b0;
        for (int i = 0; i < PATTERN_W; i++) begin
            mask[i] = (i < int'(cfg_len));
        end
        raw_match = (((w ^ cfg_pat) & mask) == '0);
    end

endmodule

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
// Runtime-programmable serial sequence detector (Mealy). Detects a pattern of
// 1..PATTERN_W bits on the qualified serial stream, overlapping or not, and
// keeps a saturating match counter.
//   clk         in  1          clock, rising edge
//   rst         in  1          asynchronous active-high reset
//   x           in  1          serial data bit
//   in_valid    in  1          x is valid this cycle
//   cfg_load    in  1          latch pattern/pat_len/overlap, restart detection
//   pattern     in  PATTERN_W  pattern, pattern[pat_len-1] received first
//   pat_len     in  LEN_W      pattern length, legal 1..PATTERN_W
//   overlap     in  1          1 = overlapping, 0 = non-overlapping detection
//   cnt_clr     in  1          synchronous clear of match_count (wins over +1)
//   z           out 1          same-cycle match flag
//   match_count out CNT_W      saturating match count
// -----------------------------------------------------------------------------
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter  int PATTERN_W = 8,
    parameter  int CNT_W     = 16,
    localparam int LEN_W     = $clog2(PATTERN_W + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 x,
    input  logic                 in_valid,
    input  logic                 cfg_load,
    input  logic [PATTERN_W-1:0] pattern,
    input  logic [LEN_W-1:0]     pat_len,
    input  logic                 overlap,
    input  logic                 cnt_clr,
    output logic                 z,
    output logic [CNT_W-1:0]     match_count
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(cnt_max(CNT_W));
    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PATTERN_W);

    // The oldest history bit would only ever be shifted out of the window,
    // so just PATTERN_W-1 previous bits are kept.
    logic [PATTERN_W-2:0] hist;
    logic [LEN_W-1:0]     fill;
    logic [PATTERN_W-1:0] cfg_pat;
    logic [LEN_W-1:0]     cfg_len;
    logic                 cfg_ovl;
    logic [CNT_W-1:0]     count_q;

    logic [PATTERN_W-1:0] w;
    logic                 raw_match;
    logic                 len_ok;
    logic                 enough;
    logic                 match;

    assign w = {hist, x};

    seq_det_window_cmp #(
        .PATTERN_W (PATTERN_W)
    ) u_cmp (
        .w         (w),
        .cfg_pat   (cfg_pat),
        .cfg_len   (cfg_len),
        .raw_match (raw_match)
    );

    assign len_ok = len_legal(32'(cfg_len), 32'(PATTERN_W));
    // Current bit plus accumulated bits must cover the whole pattern, so stale
    // history from before a restart never completes a match.
    assign enough = (32'(fill) + 32'd1) >= 32'(cfg_len);
    assign match  = in_valid & len_ok & enough & raw_match;

    // cfg_load discards the same-cycle bit, so it also masks the flag.
    assign z = match & ~cfg_load;

    assign match_count = count_q;

    // Detector state: history, fill level and latched configuration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist    <= '0;
            fill    <= '0;
            cfg_pat <= '0;
            cfg_len <= '0;      // illegal: idle until the first cfg_load
            cfg_ovl <= OVL_ON;
        end else if (cfg_load) begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            cfg_pat <= pattern;
            cfg_len <= pat_len;
            cfg_ovl <= overlap;
            hist    <= '0;
            fill    <= '0;
        end else if (in_valid) begin
            hist <= w[PATTERN_W-2:0];
            if (match && (cfg_ovl == OVL_OFF)) begin
                fill <= '0;     // consumed bits may not start the next match
            end else if (fill != FILL_MAX) begin
                fill <= fill + LEN_W'(1);
            end
        end
    end

    // Saturating match counter; clear has priority over a coincident match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (cnt_clr) begin
            count_q <= '0;
        end else if (z && (count_q != CNT_MAX)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_param
// Self-checking bench. Two detectors share all inputs: dut_a (8-bit pattern,
// 16-bit counter) and dut_b (8-bit pattern, 4-bit counter) for saturation.
// The reference model keeps the list of valid bits since the last restart and
// compares its tail directly against the latched pattern.
// -----------------------------------------------------------------------------
module tb_seq_detector_param;

    localparam int PW = 8;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          x;
    logic          in_valid;
    logic          cfg_load;
    logic [PW-1:0] pattern;
    logic [LW-1:0] pat_len;
    logic          overlap;
    logic          cnt_clr;
    logic          z_a;
    logic          z_b;
    logic [15:0]   cnt_a;
    logic [3:0]    cnt_b;

    always #5 clk = ~clk;

    seq_detector_param #(.PATTERN_W(PW), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .cfg_load(cfg_load),
        .pattern(pattern), .pat_len(pat_len), .overlap(overlap),
        .cnt_clr(cnt_clr), .z(z_a), .match_count(cnt_a)
    );

    seq_detector_param #(.PATTERN_W(PW), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .cfg_load(cfg_load),
        .pattern(pattern), .pat_len(pat_len), .overlap(overlap),
        .cnt_clr(cnt_clr), .z(z_b), .match_count(cnt_b)
    );

    int num_checks = 0;
    int num_fails  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit            q[$];
    logic [PW-1:0] m_pat;
    int            m_len;
    bit            m_ovl;
    int            exp_a;
    int            exp_b;

    task automatic model_reset();
        q.delete();
        m_pat = '0;
        m_len = 0;
        m_ovl = 1'b1;
        exp_a = 0;
        exp_b = 0;
    endtask

    // True when the bits since restart, followed by xb, end with the pattern
    // (pattern[len-1] oldest ... pattern[0] newest).
    function automatic bit model_match(input bit xb);
        bit win[$];
        if (m_len < 1 || m_len > PW) return 1'b0;
        win = q;
        win.push_back(xb);
        if (win.size() < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            if (win[win.size() - 1 - k] != m_pat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // One clock cycle: apply inputs, check z mid-cycle, advance, check counts.
    task automatic drive(input bit v, input bit xb, input bit ld, input bit clr, output bit zs);
        bit ez;
        @(negedge clk);
        in_valid = v;
        x        = xb;
        cfg_load = ld;
        cnt_clr  = clr;
        #1;
        ez = v && !ld && model_match(xb);
        check("z", 32'(z_a), 32'(ez));
        check("z_b", 32'(z_b), 32'(ez));
        zs = z_a;
        @(posedge clk);
        #1;
        if (ld) begin
            m_pat = pattern;
            m_len = int'(pat_len);
            m_ovl = overlap;
            q.delete();
        end else if (v) begin
            q.push_back(xb);
            if (q.size() > PW) void'(q.pop_front());
            if (ez && !m_ovl) q.delete();
        end
        if (clr) begin
            exp_a = 0;
            exp_b = 0;
        end else if (ez) begin
            if (exp_a < 65535) exp_a++;
            if (exp_b < 15)    exp_b++;
        end
        check("count_a", 32'(cnt_a), 32'(exp_a));
        check("count_b", 32'(cnt_b), 32'(exp_b));
    endtask

    task automatic load(input logic [PW-1:0] p, input logic [LW-1:0] l, input bit o, input bit clr);
        bit zs;
        pattern = p;
        pat_len = l;
        overlap = o;
        drive(1'b1, 1'($urandom_range(0, 1)), 1'b1, clr, zs);
    endtask

    // Send n valid bits MSB first with 'gap' invalid cycles after each; zv
    // collects z per valid bit, first bit in the highest position.
    task automatic stream(input logic [31:0] bits, input int n, input int gap, output logic [31:0] zv);
        bit zs;
        bit zg;
        zv = '0;
        for (int i = n - 1; i >= 0; i--) begin
            drive(1'b1, bits[i], 1'b0, 1'b0, zs);
            zv = {zv[30:0], zs};
            for (int g = 0; g < gap; g++) begin
                drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, zg);
            end
        end
    endtask

    initial begin
        logic [31:0] zv;
        bit          zs;

        rst = 1'b1; x = 1'b0; in_valid = 1'b0; cfg_load = 1'b0;
        pattern = '0; pat_len = '0; overlap = 1'b0; cnt_clr = 1'b0;
        model_reset();
        #12;
        check("reset_z", 32'(z_a), 32'd0);
        check("reset_count", 32'(cnt_a), 32'd0);
        check("reset_count_b", 32'(cnt_b), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Idle after reset: no configuration yet, so nothing may match.
        stream(32'b101, 3, 0, zv);
        check("idle_after_reset", zv, 32'd0);

        // Overlapping 101.
        load(8'b101, 4'd3, 1'b1, 1'b1);
        stream(32'b1010101, 7, 0, zv);
        check("ovl_101_z", zv, 32'b0010101);
        check("ovl_101_count", 32'(cnt_a), 32'd3);

        // Non-overlapping 101.
        load(8'b101, 4'd3, 1'b0, 1'b1);
        stream(32'b1010101, 7, 0, zv);
        check("novl_101_z", zv, 32'b0010001);
        check("novl_101_count", 32'(cnt_a), 32'd2);

        // Full-width pattern with 2-cycle gaps between valid bits.
        load(8'hA5, 4'd8, 1'b1, 1'b1);
        stream(32'hA5, 8, 2, zv);
        check("a5_gapped_z", zv, 32'd1);
        check("a5_gapped_count", 32'(cnt_a), 32'd1);

        // Length-1 pattern: counter saturation and clear priority.
        load(8'h01, 4'd1, 1'b1, 1'b1);
        stream(32'hFFFFF, 20, 0, zv);
        check("sat_count_a", 32'(cnt_a), 32'd20);
        check("sat_count_b", 32'(cnt_b), 32'd15);
        drive(1'b1, 1'b1, 1'b0, 1'b1, zs);
        check("clr_with_match_z", 32'(zs), 32'd1);
        check("clr_with_match_a", 32'(cnt_a), 32'd0);
        check("clr_with_match_b", 32'(cnt_b), 32'd0);

        // Restart by cfg_load drops partial progress; count is kept.
        load(8'b101, 4'd3, 1'b1, 1'b1);
        stream(32'b101, 3, 0, zv);
        stream(32'b10, 2, 0, zv);
        load(8'b101, 4'd3, 1'b1, 1'b0);
        stream(32'b1, 1, 0, zv);
        check("restart_no_z", zv, 32'd0);
        stream(32'b01, 2, 0, zv);
        check("restart_then_match", zv, 32'b01);
        check("restart_count_kept", 32'(cnt_a), 32'd2);

        // Asynchronous reset mid-stream.
        stream(32'b10, 2, 0, zv);
        @(negedge clk);
        in_valid = 1'b1; x = 1'b1; cfg_load = 1'b0; cnt_clr = 1'b0;
        #1;
        check("pre_rst_z", 32'(z_a), 32'(model_match(1'b1)));
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check("async_rst_z", 32'(z_a), 32'd0);
        check("async_rst_count", 32'(cnt_a), 32'd0);
        check("async_rst_count_b", 32'(cnt_b), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        stream(32'b10101, 5, 0, zv);
        check("post_rst_idle", zv, 32'd0);

        // Illegal lengths: never match.
        load(8'hFF, 4'd0, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, zs);
        check("len0_count", 32'(cnt_a), 32'd0);
        load(8'h00, 4'd9, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, zs);
        check("len9_count", 32'(cnt_a), 32'd0);

        // Randomized traffic against the model.
        for (int seg = 0; seg < 30; seg++) begin
            load(PW'($urandom), LW'($urandom_range(1, (seg % 3 == 0) ? 8 : 4)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int c = 0; c < 60; c++) begin
                pattern = PW'($urandom);
                pat_len = LW'($urandom_range(0, 9));
                overlap = 1'($urandom_range(0, 1));
                drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 29) == 0), zs);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
